// File: rtl/gcd_pkg.sv
// gcd_pkg: shared definitions for the GCD engine.
//   state_t  : FSM state encoding (IDLE / CALC / DONE)
//   ALGO_SUB : subtractive Euclid datapath selector
//   ALGO_BIN : binary (Stein) datapath selector
package gcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int ALGO_SUB = 0;
  localparam int ALGO_BIN = 1;

endpackage

// File: rtl/gcd_abs.sv
// gcd_abs: combinational two's-complement to magnitude conversion.
//   num : signed operand, WIDTH bits
//   mag : unsigned magnitude, WIDTH bits
// The most-negative value maps onto itself, which read as unsigned is the
// correct magnitude (e.g. -128 -> 0x80), so no overflow flag is needed.
module gcd_abs #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] num,
  output logic [WIDTH-1:0] mag
);

  assign mag = num[WIDTH-1] ? -num : num;

endmodule

// File: rtl/gcd_engine.sv
// gcd_engine: signed-input GCD engine with valid/ready on both sides.
//   clk       : clock, all logic on posedge
//   rst       : synchronous active-low reset
//   abort     : return to IDLE, dropping any in-flight operation
//   in_valid  / in_ready  : operand handshake (in_ready only in IDLE)
//   num_a, num_b          : signed operands
//   out_valid / out_ready : result handshake (out_valid only in DONE)
//   gcd_out   : |GCD(A,B)|
//   iter_cnt  : CALC cycles spent, including the terminating one (saturating)
//
// state   | meaning
// --------+-------------------------------------------------
// ST_IDLE | waiting for operands, in_ready=1
// ST_CALC | one algorithm step per cycle
// ST_DONE | result presented, held until out_ready
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ALGO  = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num_a,
  input  logic [WIDTH-1:0] num_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic [CNT_W-1:0] iter_cnt
);

  localparam int KW = $clog2(WIDTH + 1);

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, gcd_q;
  logic [KW-1:0]    k_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] step_a, step_b, step_res;
  logic [KW-1:0]    step_k;
  logic             step_done;
  logic             load;

  gcd_abs #(.WIDTH(WIDTH)) u_abs_a (.num(num_a), .mag(mag_a));
  gcd_abs #(.WIDTH(WIDTH)) u_abs_b (.num(num_b), .mag(mag_b));

  generate
    if (ALGO == ALGO_BIN) begin : g_bin
      always_comb begin
        step_a    = a_q;
        step_b    = b_q;
        step_k    = k_q;
        step_done = 1'b0;
        step_res  = '0;
        if (a_q == '0) begin
          step_done = 1'b1;
          step_res  = b_q << k_q;
        end else if (b_q == '0) begin
          step_done = 1'b1;
          step_res  = a_q << k_q;
        end else if (a_q == b_q) begin
          step_done = 1'b1;
          step_res  = a_q << k_q;
        end else if (!a_q[0] && !b_q[0]) begin
          step_a = a_q >> 1;
          step_b = b_q >> 1;
          step_k = k_q + KW'(1);
        end else if (!a_q[0]) begin
          step_a = a_q >> 1;
        end else if (!b_q[0]) begin
          step_b = b_q >> 1;
        end else if (a_q > b_q) begin
          step_a = a_q - b_q;
        end else begin
          step_b = b_q - a_q;
        end
      end
    end else begin : g_sub
      always_comb begin
        step_a    = a_q;
        step_b    = b_q;
        step_k    = k_q;
        step_done = 1'b0;
        step_res  = '0;
        if (a_q == '0) begin
          step_done = 1'b1;
          step_res  = b_q;
        end else if (b_q == '0) begin
          step_done = 1'b1;
          step_res  = a_q;
        end else if (a_q == b_q) begin
          step_done = 1'b1;
          step_res  = a_q;
        end else if (a_q > b_q) begin
          step_a = a_q - b_q;
        end else begin
          step_b = b_q - a_q;
        end
      end
    end
  endgenerate

  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt = ST_CALC;
          load      = 1'b1;
        end
      end
      ST_CALC: if (step_done) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    // abort beats both handshakes
    if (abort) begin
      state_nxt = ST_IDLE;
      load      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      gcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      if (load) begin
        a_q   <= mag_a;
        b_q   <= mag_b;
        k_q   <= '0;
        cnt_q <= '0;
      end else if (state_q == ST_CALC && !abort) begin
        a_q   <= step_a;
        b_q   <= step_b;
        k_q   <= step_k;
        cnt_q <= (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        if (step_done) gcd_q <= step_res;
      end
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign gcd_out   = gcd_q;
  assign iter_cnt  = cnt_q;

endmodule

// File: tb/tb_gcd_engine.sv
module tb_gcd_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       abort_s[3];
  logic       in_valid_s[3];
  logic       out_ready_s[3];
  logic [7:0] num_a_s[3];
  logic [7:0] num_b_s[3];

  logic       ir0, ir1, ir2, ov0, ov1, ov2;
  logic [7:0] g0, g1, g2, c0, c1;
  logic [3:0] c2;

  logic       ir_s[3];
  logic       ov_s[3];
  logic [7:0] go_s[3];
  logic [7:0] ic_s[3];

  int tests = 0;
  int fails = 0;

  gcd_engine #(.WIDTH(8), .ALGO(0), .CNT_W(8)) u_sub (
    .clk(clk), .rst(rst), .abort(abort_s[0]), .in_valid(in_valid_s[0]), .in_ready(ir0),
    .num_a(num_a_s[0]), .num_b(num_b_s[0]), .out_valid(ov0), .out_ready(out_ready_s[0]),
    .gcd_out(g0), .iter_cnt(c0));

  gcd_engine #(.WIDTH(8), .ALGO(1), .CNT_W(8)) u_bin (
    .clk(clk), .rst(rst), .abort(abort_s[1]), .in_valid(in_valid_s[1]), .in_ready(ir1),
    .num_a(num_a_s[1]), .num_b(num_b_s[1]), .out_valid(ov1), .out_ready(out_ready_s[1]),
    .gcd_out(g1), .iter_cnt(c1));

  gcd_engine #(.WIDTH(8), .ALGO(0), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .abort(abort_s[2]), .in_valid(in_valid_s[2]), .in_ready(ir2),
    .num_a(num_a_s[2]), .num_b(num_b_s[2]), .out_valid(ov2), .out_ready(out_ready_s[2]),
    .gcd_out(g2), .iter_cnt(c2));

  always_comb begin
    ir_s[0] = ir0; ir_s[1] = ir1; ir_s[2] = ir2;
    ov_s[0] = ov0; ov_s[1] = ov1; ov_s[2] = ov2;
    go_s[0] = g0;  go_s[1] = g1;  go_s[2] = g2;
    ic_s[0] = c0;  ic_s[1] = c1;  ic_s[2] = {4'b0000, c2};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mag(input logic [7:0] v);
    return v[7] ? 256 - int'(v) : int'(v);
  endfunction

  function automatic int ref_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Number of algorithm steps, counting the terminating step.
  function automatic int ref_iters(input int algo, input int a, input int b);
    for (int n = 1; n < 1000; n++) begin
      if (a == 0 || b == 0 || a == b) return n;
      if (algo == 1 && a % 2 == 0 && b % 2 == 0) begin
        a = a / 2; b = b / 2;
      end else if (algo == 1 && a % 2 == 0) a = a / 2;
      else if (algo == 1 && b % 2 == 0) b = b / 2;
      else if (a > b) a = a - b;
      else b = b - a;
    end
    return 1000;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered and left at a negedge; the accept edge happens inside.
  task automatic start_op(input int d, input logic [7:0] a, input logic [7:0] b);
    num_a_s[d]    = a;
    num_b_s[d]    = b;
    in_valid_s[d] = 1'b1;
    chk("in_ready_before_accept", ir_s[d], 1);
    tick();
    in_valid_s[d] = 1'b0;
  endtask

  task automatic finish_op(input int d, input logic [7:0] a, input logic [7:0] b,
                           input int hold, input bit release_it);
    int g, n, ncap, edges;
    g     = ref_gcd(mag(a), mag(b));
    n     = ref_iters(d == 1 ? 1 : 0, mag(a), mag(b));
    ncap  = (d == 2 && n > 15) ? 15 : n;
    edges = 1;
    while (!ov_s[d] && edges < 600) begin
      tick();
      edges++;
    end
    chk("latency_edges", edges, n + 1);
    chk("gcd_out", go_s[d], g);
    chk("iter_cnt", ic_s[d], ncap);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_out_valid", ov_s[d], 1);
      chk("hold_gcd_out", go_s[d], g);
      chk("hold_in_ready", ir_s[d], 0);
    end
    if (release_it) begin
      out_ready_s[d] = 1'b1;
      tick();
      out_ready_s[d] = 1'b0;
      chk("released_out_valid", ov_s[d], 0);
      chk("released_in_ready", ir_s[d], 1);
    end
  endtask

  task automatic full_op(input int d, input logic [7:0] a, input logic [7:0] b, input int hold);
    start_op(d, a, b);
    finish_op(d, a, b, hold, 1'b1);
  endtask

  initial begin
    int seen;
    logic [7:0] ra, rb;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      abort_s[d] = 1'b0; in_valid_s[d] = 1'b0; out_ready_s[d] = 1'b0;
      num_a_s[d] = '0;   num_b_s[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_in_ready", ir_s[d], 1);
      chk("reset_out_valid", ov_s[d], 0);
      chk("reset_gcd_out", go_s[d], 0);
      chk("reset_iter_cnt", ic_s[d], 0);
    end
    rst = 1'b1;
    tick();

    full_op(0, 8'd48, 8'd18, 0);
    full_op(1, 8'd48, 8'd18, 0);
    full_op(0, 8'hF4, 8'd8, 0);
    full_op(1, 8'hF4, 8'd8, 0);
    full_op(0, 8'd0, 8'd0, 0);
    full_op(1, 8'd0, 8'd0, 0);
    full_op(0, 8'h80, 8'd0, 0);
    full_op(1, 8'h80, 8'd0, 0);
    full_op(0, 8'd7, 8'd7, 0);
    full_op(1, 8'd7, 8'd7, 0);
    full_op(0, 8'd100, 8'd75, 10);
    full_op(1, 8'd100, 8'd75, 10);
    full_op(2, 8'd127, 8'd1, 0);

    // abort mid-CALC, then a fresh operation
    start_op(0, 8'd127, 8'd1);
    repeat (5) tick();
    abort_s[0] = 1'b1;
    tick();
    abort_s[0] = 1'b0;
    chk("abort_in_ready", ir0, 1);
    chk("abort_out_valid", ov0, 0);
    seen = 0;
    repeat (150) begin
      tick();
      if (ov0) seen++;
    end
    chk("abort_no_result", seen, 0);
    full_op(0, 8'd9, 8'd6, 0);

    // abort together with in_valid: operands not taken
    num_a_s[1] = 8'd9; num_b_s[1] = 8'd6;
    in_valid_s[1] = 1'b1; abort_s[1] = 1'b1;
    tick();
    in_valid_s[1] = 1'b0; abort_s[1] = 1'b0;
    chk("abort_accept_in_ready", ir1, 1);
    seen = 0;
    repeat (20) begin
      tick();
      if (ov1) seen++;
    end
    chk("abort_accept_no_result", seen, 0);

    // abort in DONE: valid drops, result registers keep their values
    start_op(1, 8'd48, 8'd18);
    finish_op(1, 8'd48, 8'd18, 0, 1'b0);
    abort_s[1] = 1'b1;
    tick();
    abort_s[1] = 1'b0;
    chk("abort_done_out_valid", ov1, 0);
    chk("abort_done_in_ready", ir1, 1);
    chk("abort_done_gcd_kept", g1, 6);
    chk("abort_done_iter_kept", ic_s[1], 7);

    // reset mid-CALC
    start_op(0, 8'd200, 8'd3);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_gcd_out", g0, 0);
    chk("rst_iter_cnt", c0, 0);
    chk("rst_out_valid", ov0, 0);
    rst = 1'b1;
    tick();
    chk("rst_release_in_ready", ir0, 1);

    for (int i = 0; i < 25; i++) begin
      for (int d = 0; d < 2; d++) begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        full_op(d, ra, rb, int'($urandom_range(0, 2)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
